// File: rtl/soin_pkg.sv
// Shared types for the RV32I front end.
// Fetch entries pair each instruction word with its PC.
package soin_pkg;
   localparam int XLEN = 32;
   typedef logic [XLEN-1:0] word_t;
   typedef struct packed {
      word_t pc;
      word_t inst;
   } fetch_entry_t;
   localparam word_t INST_NOP = 32'h0000_0013;
endpackage

// File: rtl/inst_fifo.sv
// Small power-of-two FIFO of fetch entries.
// Flush is synchronous; reset clears storage so the head reads as zero.
module inst_fifo
   import soin_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                     i_clk,
   input  logic                     i_rst,
   input  logic                     i_flush,
   input  logic                     i_push,
   input  fetch_entry_t             i_data,
   input  logic                     i_pop,
   output fetch_entry_t             o_data,
   output logic                     o_full,
   output logic                     o_empty,
   output logic [$clog2(DEPTH):0]   o_count
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   fetch_entry_t    mem_q [DEPTH];
   logic [AW-1:0]   wr_q;
   logic [AW-1:0]   rd_q;
   logic [CW-1:0]   cnt_q;
   logic [CW-1:0]   cnt_d;

   assign cnt_d   = cnt_q + CW'(i_push) - CW'(i_pop);
   assign o_data  = mem_q[rd_q];
   assign o_count = cnt_q;
   assign o_empty = (cnt_q == '0);
   assign o_full  = (cnt_q == CW'(DEPTH));

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         wr_q  <= '0;
         rd_q  <= '0;
         cnt_q <= '0;
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      end else if (i_flush) begin
         wr_q  <= '0;
         rd_q  <= '0;
         cnt_q <= '0;
      end else begin
         if (i_push) begin
            mem_q[wr_q] <= i_data;
            wr_q        <= wr_q + 1'b1;
         end
         if (i_pop) rd_q <= rd_q + 1'b1;
         cnt_q <= cnt_d;
      end
   end
endmodule

// File: rtl/if_prefetch.sv
// Instruction prefetch stage: credit-limited in-order fetch,
// PC-tagged buffering and redirect flush with stale-response discard.
module if_prefetch
   import soin_pkg::*;
#(
   parameter int    DEPTH    = 4,
   parameter word_t RESET_PC = 32'h0000_0000
) (
   input  logic         i_clk,
   input  logic         i_rst,
   output logic         o_imem_req,
   output logic [31:0]  o_imem_addr,
   input  logic         i_imem_gnt,
   input  logic         i_imem_rvalid,
   input  logic [31:0]  i_imem_rdata,
   output logic         o_inst_valid,
   output logic [31:0]  o_inst,
   output logic [31:0]  o_inst_pc,
   input  logic         i_inst_ready,
   input  logic         i_redirect,
   input  logic [31:0]  i_redirect_pc
);
   localparam int CW = $clog2(DEPTH) + 1;
   localparam logic [CW:0] CAP = (CW+1)'(DEPTH);

   word_t         fetch_pc_q, fetch_pc_d;
   word_t         resp_pc_q, resp_pc_d;
   logic [CW-1:0] outst_q, outst_d;
   logic [CW-1:0] disc_q, disc_d;
   logic [CW-1:0] count;
   logic [CW:0]   used;
   logic          fire, rv_ok, keep, pop;
   logic          full, empty;
   word_t         tgt;
   fetch_entry_t  head, push_data;

   assign tgt  = i_redirect_pc & 32'hFFFF_FFFC;
   assign used = {1'b0, count} + {1'b0, outst_q};

   // Discarded responses still hold credit until they come back.
   assign o_imem_req  = ~i_rst & ~i_redirect & (used < CAP);
   assign o_imem_addr = fetch_pc_q;

   assign fire  = o_imem_req & i_imem_gnt;
   assign rv_ok = i_imem_rvalid & (outst_q != '0);
   assign keep  = rv_ok & (disc_q == '0) & ~i_redirect;
   assign pop   = ~empty & i_inst_ready & ~i_redirect;

   assign push_data = '{pc: resp_pc_q, inst: i_imem_rdata};

   always_comb begin
      outst_d    = outst_q + CW'(fire) - CW'(rv_ok);
      disc_d     = disc_q;
      fetch_pc_d = fetch_pc_q;
      resp_pc_d  = resp_pc_q;
      if (i_redirect) begin
         disc_d     = outst_q - CW'(rv_ok);
         fetch_pc_d = tgt;
         resp_pc_d  = tgt;
      end else begin
         if (rv_ok && disc_q != '0) disc_d = disc_q - CW'(1);
         if (fire) fetch_pc_d = fetch_pc_q + 32'd4;
         if (keep) resp_pc_d = resp_pc_q + 32'd4;
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         fetch_pc_q <= RESET_PC;
         resp_pc_q  <= RESET_PC;
         outst_q    <= '0;
         disc_q     <= '0;
      end else begin
         fetch_pc_q <= fetch_pc_d;
         resp_pc_q  <= resp_pc_d;
         outst_q    <= outst_d;
         disc_q     <= disc_d;
      end
   end

   inst_fifo #(.DEPTH(DEPTH)) u_fifo (
      .i_clk   (i_clk),
      .i_rst   (i_rst),
      .i_flush (i_redirect),
      .i_push  (keep),
      .i_data  (push_data),
      .i_pop   (pop),
      .o_data  (head),
      .o_full  (full),
      .o_empty (empty),
      .o_count (count)
   );

   assign o_inst_valid = ~empty;
   assign o_inst       = head.inst;
   assign o_inst_pc    = head.pc;

   a_no_orphan_rvalid: assert property (
      @(posedge i_clk) disable iff (i_rst)
      !(i_imem_rvalid && outst_q == '0));

   a_no_overflow: assert property (
      @(posedge i_clk) disable iff (i_rst)
      !(keep && full && !pop));
endmodule

// File: tb/tb_if_prefetch.sv
// Bench for if_prefetch: random in-order memory responder and
// a stream-level model of which PCs decode should see.
module tb_if_prefetch;
   import soin_pkg::*;

   logic        clk;
   logic        i_rst;
   logic        o_imem_req;
   logic [31:0] o_imem_addr;
   logic        i_imem_gnt;
   logic        i_imem_rvalid;
   logic [31:0] i_imem_rdata;
   logic        o_inst_valid;
   logic [31:0] o_inst;
   logic [31:0] o_inst_pc;
   logic        i_inst_ready;
   logic        i_redirect;
   logic [31:0] i_redirect_pc;

   if_prefetch #(.DEPTH(4), .RESET_PC(32'h0)) dut (
      .i_clk         (clk),
      .i_rst         (i_rst),
      .o_imem_req    (o_imem_req),
      .o_imem_addr   (o_imem_addr),
      .i_imem_gnt    (i_imem_gnt),
      .i_imem_rvalid (i_imem_rvalid),
      .i_imem_rdata  (i_imem_rdata),
      .o_inst_valid  (o_inst_valid),
      .o_inst        (o_inst),
      .o_inst_pc     (o_inst_pc),
      .i_inst_ready  (i_inst_ready),
      .i_redirect    (i_redirect),
      .i_redirect_pc (i_redirect_pc)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] addr;
      int          due;
   } mreq_t;

   mreq_t       mq[$];
   int          checks = 0;
   int          failures = 0;
   int          cyc = 0;
   int          gnt_pct = 100, rv_pct = 100, rdy_pct = 100, lat_max = 0;
   logic [31:0] exp_addr, exp_pc;
   bit          prev_hold, prev_redir;
   logic [31:0] prev_inst, prev_pc;
   bit          obs_req, obs_valid, obs_rv, obs_pop, obs_fire;
   int          n_fire = 0, n_cons = 0;
   logic [31:0] last_cons_pc;

   function automatic logic [31:0] memfn(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ INST_NOP;
   endfunction

   task automatic hold_reset();
      i_rst         = 1'b1;
      i_imem_gnt    = 1'b0;
      i_imem_rvalid = 1'b0;
      i_imem_rdata  = '0;
      i_inst_ready  = 1'b0;
      i_redirect    = 1'b0;
      i_redirect_pc = '0;
      mq.delete();
   endtask

   task automatic release_reset();
      @(negedge clk);
      i_rst      = 1'b0;
      exp_addr   = 32'h0;
      exp_pc     = 32'h0;
      prev_hold  = 1'b0;
      prev_redir = 1'b0;
   endtask

   task automatic step(input bit redir, input logic [31:0] rpc);
      @(negedge clk);
      i_redirect    = redir;
      i_redirect_pc = rpc;
      i_inst_ready  = ($urandom_range(99) < rdy_pct);
      i_imem_gnt    = ($urandom_range(99) < gnt_pct);
      if (mq.size() > 0 && mq[0].due <= cyc && $urandom_range(99) < rv_pct) begin
         i_imem_rvalid = 1'b1;
         i_imem_rdata  = memfn(mq[0].addr);
      end else begin
         i_imem_rvalid = 1'b0;
         i_imem_rdata  = $urandom;
      end
      #1;
      obs_req   = o_imem_req;
      obs_valid = o_inst_valid;
      obs_rv    = i_imem_rvalid;
      obs_pop   = o_inst_valid & i_inst_ready;
      obs_fire  = o_imem_req & i_imem_gnt;
      if (prev_redir) begin
         checks++;
         if (o_inst_valid !== 1'b0) begin
            failures++;
            $display("FAIL valid_after_redirect got=%b exp=0", o_inst_valid);
         end
      end
      if (prev_hold) begin
         checks++;
         if (o_inst_valid !== 1'b1 || o_inst !== prev_inst || o_inst_pc !== prev_pc) begin
            failures++;
            $display("FAIL stall_hold got=%b/%h/%h exp=1/%h/%h",
                     o_inst_valid, o_inst_pc, o_inst, prev_pc, prev_inst);
         end
      end
      if (redir) begin
         checks++;
         if (o_imem_req !== 1'b0) begin
            failures++;
            $display("FAIL req_in_redirect got=%b exp=0", o_imem_req);
         end
      end
      if (o_imem_req === 1'b1) begin
         checks++;
         if (o_imem_addr !== exp_addr) begin
            failures++;
            $display("FAIL req_addr got=%h exp=%h", o_imem_addr, exp_addr);
         end
      end
      if (o_inst_valid === 1'b1 && i_inst_ready && !redir) begin
         checks++;
         if (o_inst_pc !== exp_pc || o_inst !== memfn(exp_pc)) begin
            failures++;
            $display("FAIL consume got=%h/%h exp=%h/%h",
                     o_inst_pc, o_inst, exp_pc, memfn(exp_pc));
         end
         last_cons_pc = o_inst_pc;
         exp_pc += 32'd4;
         n_cons++;
      end
      prev_hold  = o_inst_valid & ~i_inst_ready & ~redir;
      prev_inst  = o_inst;
      prev_pc    = o_inst_pc;
      prev_redir = redir;
      if (i_imem_rvalid) void'(mq.pop_front());
      if (obs_fire) begin
         mq.push_back('{o_imem_addr, cyc + 1 + int'($urandom_range(lat_max))});
         exp_addr += 32'd4;
         n_fire++;
      end
      if (redir) begin
         exp_addr = rpc & 32'hFFFF_FFFC;
         exp_pc   = rpc & 32'hFFFF_FFFC;
      end
      cyc++;
   endtask

   task automatic set_knobs(input int g, input int r, input int d, input int l);
      gnt_pct = g;
      rv_pct  = r;
      rdy_pct = d;
      lat_max = l;
   endtask

   task automatic test_reset();
      @(negedge clk);
      hold_reset();
      #1;
      checks++;
      if (o_imem_req !== 1'b0 || o_imem_addr !== 32'h0 || o_inst_valid !== 1'b0 ||
          o_inst !== 32'h0 || o_inst_pc !== 32'h0) begin
         failures++;
         $display("FAIL reset_values got=%b/%h/%b/%h/%h exp=0/0/0/0/0",
                  o_imem_req, o_imem_addr, o_inst_valid, o_inst, o_inst_pc);
      end
      repeat (2) @(negedge clk);
      checks++;
      if (o_imem_req !== 1'b0) begin
         failures++;
         $display("FAIL req_during_reset got=%b exp=0", o_imem_req);
      end
      release_reset();
      #1;
      checks++;
      if (o_imem_req !== 1'b1 || o_imem_addr !== 32'h0) begin
         failures++;
         $display("FAIL first_req got=%b/%h exp=1/00000000", o_imem_req, o_imem_addr);
      end
   endtask

   task automatic test_stream();
      int n0;
      set_knobs(100, 100, 100, 0);
      repeat (3) step(1'b0, 32'h0);
      checks++;
      if (n_cons != 1 || last_cons_pc !== 32'h0) begin
         failures++;
         $display("FAIL first_inst got=%0d/%h exp=1/00000000", n_cons, last_cons_pc);
      end
      repeat (3) step(1'b0, 32'h0);
      n0 = n_cons;
      repeat (20) step(1'b0, 32'h0);
      checks++;
      if (n_cons - n0 != 20) begin
         failures++;
         $display("FAIL throughput got=%0d exp=20", n_cons - n0);
      end
   endtask

   task automatic test_backpressure();
      int f0;
      @(negedge clk);
      hold_reset();
      release_reset();
      set_knobs(100, 100, 0, 0);
      f0 = n_fire;
      repeat (10) step(1'b0, 32'h0);
      checks++;
      if (n_fire - f0 != 4 || obs_req !== 1'b0) begin
         failures++;
         $display("FAIL credit_limit got=%0d/%b exp=4/0", n_fire - f0, obs_req);
      end
      checks++;
      if (o_inst_valid !== 1'b1 || o_inst_pc !== 32'h0 || o_inst !== INST_NOP) begin
         failures++;
         $display("FAIL stalled_head got=%b/%h/%h exp=1/00000000/%h",
                  o_inst_valid, o_inst_pc, o_inst, INST_NOP);
      end
      rdy_pct = 100;
      step(1'b0, 32'h0);
      rdy_pct = 0;
      step(1'b0, 32'h0);
      checks++;
      if (obs_req !== 1'b1 || o_imem_addr !== 32'h10) begin
         failures++;
         $display("FAIL resume_req got=%b/%h exp=1/00000010", obs_req, o_imem_addr);
      end
      step(1'b0, 32'h0);
      checks++;
      if (obs_req !== 1'b0) begin
         failures++;
         $display("FAIL one_per_pop got=%b exp=0", obs_req);
      end
      rdy_pct = 100;
      repeat (8) step(1'b0, 32'h0);
   endtask

   task automatic test_redirect();
      int n0, k;
      @(negedge clk);
      hold_reset();
      release_reset();
      set_knobs(100, 0, 100, 0);
      repeat (3) step(1'b0, 32'h0);
      checks++;
      if (mq.size() != 3) begin
         failures++;
         $display("FAIL inflight got=%0d exp=3", mq.size());
      end
      rv_pct = 100;
      step(1'b1, 32'h0000_0102);
      n0 = n_cons;
      k = 0;
      while (n_cons == n0 && k < 40) begin
         step(1'b0, 32'h0);
         k++;
      end
      checks++;
      if (n_cons == n0 || last_cons_pc !== 32'h100 || k < 3) begin
         failures++;
         $display("FAIL redirect_first got=%h/%0d exp=00000100/>=3", last_cons_pc, k);
      end
      repeat (6) step(1'b0, 32'h0);
   endtask

   task automatic test_redirect_collide();
      int n0, k;
      set_knobs(100, 100, 100, 0);
      repeat (6) step(1'b0, 32'h0);
      step(1'b1, 32'h0000_0200);
      checks++;
      if (obs_rv !== 1'b1 || obs_pop !== 1'b1) begin
         failures++;
         $display("FAIL collide_setup got=%b/%b exp=1/1", obs_rv, obs_pop);
      end
      n0 = n_cons;
      step(1'b0, 32'h0);
      checks++;
      if (obs_valid !== 1'b0) begin
         failures++;
         $display("FAIL collide_empty got=%b exp=0", obs_valid);
      end
      k = 0;
      while (n_cons == n0 && k < 40) begin
         step(1'b0, 32'h0);
         k++;
      end
      checks++;
      if (n_cons == n0 || last_cons_pc !== 32'h200) begin
         failures++;
         $display("FAIL collide_restart got=%h exp=00000200", last_cons_pc);
      end
   endtask

   task automatic test_wrap();
      logic [31:0] seen[$];
      int n0, k;
      set_knobs(100, 100, 100, 1);
      step(1'b1, 32'hFFFF_FFF8);
      n0 = n_cons;
      k = 0;
      while (seen.size() < 3 && k < 60) begin
         step(1'b0, 32'h0);
         if (n_cons != n0) begin
            seen.push_back(last_cons_pc);
            n0 = n_cons;
         end
         k++;
      end
      checks++;
      if (seen.size() < 3) begin
         failures++;
         $display("FAIL wrap_count got=%0d exp=3", seen.size());
      end else if (seen[0] !== 32'hFFFF_FFF8 || seen[1] !== 32'hFFFF_FFFC ||
                   seen[2] !== 32'h0) begin
         failures++;
         $display("FAIL wrap_seq got=%h,%h,%h exp=fffffff8,fffffffc,00000000",
                  seen[0], seen[1], seen[2]);
      end
   endtask

   task automatic test_reset_mid();
      int k, n0;
      set_knobs(80, 50, 100, 3);
      k = 0;
      while ((mq.size() == 0 || k < 6) && k < 40) begin
         step(1'b0, 32'h0);
         k++;
      end
      checks++;
      if (mq.size() == 0) begin
         failures++;
         $display("FAIL mid_reset_setup got=0 exp=>0");
      end
      #2;
      hold_reset();
      #1;
      checks++;
      if (o_imem_req !== 1'b0 || o_imem_addr !== 32'h0 || o_inst_valid !== 1'b0 ||
          o_inst !== 32'h0 || o_inst_pc !== 32'h0) begin
         failures++;
         $display("FAIL mid_reset got=%b/%h/%b/%h/%h exp=0/0/0/0/0",
                  o_imem_req, o_imem_addr, o_inst_valid, o_inst, o_inst_pc);
      end
      @(negedge clk);
      release_reset();
      n0 = n_cons;
      repeat (30) step(1'b0, 32'h0);
      checks++;
      if (n_cons - n0 < 3) begin
         failures++;
         $display("FAIL restart_progress got=%0d exp=>=3", n_cons - n0);
      end
   endtask

   task automatic test_random();
      int n0;
      logic [31:0] rpc;
      set_knobs(70, 70, 60, 3);
      n0 = n_cons;
      for (int i = 0; i < 1500; i++) begin
         if ($urandom_range(99) < 3) begin
            rpc = ($urandom_range(3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(15)))
                                            : $urandom;
            step(1'b1, rpc);
         end else begin
            step(1'b0, 32'h0);
         end
      end
      checks++;
      if (n_cons - n0 < 200) begin
         failures++;
         $display("FAIL random_progress got=%0d exp=>=200", n_cons - n0);
      end
   endtask

   initial begin
      hold_reset();
      test_reset();
      test_stream();
      test_backpressure();
      test_redirect();
      test_redirect_collide();
      test_wrap();
      test_reset_mid();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
